// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART transmitter.
// UART_TX_PARITY_EN adds an even-parity bit between the data and stop bits.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 868;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    PARITY
  } state_t;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] i_data);
    return ^i_data;
  endfunction
`else
  localparam int FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;
`endif

endpackage

// File: rtl/uart_tx_serializer_baud_tick.sv
// Bit-period timer: o_bit_tick pulses on the last cycle of every CLKS_PER_BIT window.
// i_clear restarts the window so the first bit of a frame is full length.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_bit_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_last;

  assign w_last     = (r_count == LAST_CNT);
  assign o_bit_tick = w_last;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (w_last) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter, LSB first, with a one-cycle IDLE between frames so tx_ready
// rises once per byte. UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 transmitter_start,
  input  logic [DATA_BITS-1:0] transmitter_data,
  output logic                 tx_ready,
  output logic                 tx_serial,
  output logic                 tx_done
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  state_t               r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [IDX_W-1:0]     r_bit_idx;
  logic                 r_tx_serial;
  logic                 r_tx_ready;
  logic                 r_tx_done;
`ifdef UART_TX_PARITY_EN
  logic                 r_parity;
`endif

  logic             w_accept;
  logic             w_bit_tick;
  logic [IDX_W-1:0] w_next_idx;

  assign w_accept   = (r_state == IDLE) && transmitter_start;
  assign w_next_idx = r_bit_idx + IDX_W'(1);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_accept),
    .o_bit_tick(w_bit_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_bit_idx   <= '0;
      r_tx_serial <= 1'b1;
      r_tx_ready  <= 1'b1;
      r_tx_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity    <= 1'b0;
`endif
    end else begin
      r_tx_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (transmitter_start) begin
            r_shift     <= transmitter_data;
            r_bit_idx   <= '0;
            r_tx_serial <= 1'b0;
            r_tx_ready  <= 1'b0;
            r_state     <= START;
`ifdef UART_TX_PARITY_EN
            r_parity    <= even_parity(transmitter_data);
`endif
          end
        end
        START: begin
          if (w_bit_tick) begin
            r_bit_idx   <= '0;
            r_tx_serial <= r_shift[0];
            r_state     <= DATA;
          end
        end
        DATA: begin
          if (w_bit_tick) begin
            if (r_bit_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
              r_tx_serial <= r_parity;
              r_state     <= PARITY;
`else
              r_tx_serial <= 1'b1;
              r_state     <= STOP;
`endif
            end else begin
              r_bit_idx   <= w_next_idx;
              r_tx_serial <= r_shift[w_next_idx];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (w_bit_tick) begin
            r_tx_serial <= 1'b1;
            r_state     <= STOP;
          end
        end
`endif
        STOP: begin
          // Ready and done rise together on the IDLE entry edge.
          if (w_bit_tick) begin
            r_tx_serial <= 1'b1;
            r_tx_ready  <= 1'b1;
            r_tx_done   <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_tx_serial <= 1'b1;
          r_tx_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign tx_ready  = r_tx_ready;
  assign tx_serial = r_tx_serial;
  assign tx_done   = r_tx_done;

endmodule
